counter: RTL and testbench

Free-running, synchronously clearable up-counter used as a small select/sequence generator in the PS/2 interface datapath, e.g. for time-multiplexing display digits or stepping through a short phase sequence. It advances once per enabled clock edge, wraps at its terminal value, and returns to zero whenever `clear` is sampled high. The output is a registered count directly usable as a mux select.

---
 rtl/counter.sv | 30 +++
 tb/tb_counter.sv | 76 +++++++
 2 files changed

// File: rtl/counter.sv
// counter: free-running up-counter with synchronous clear and optional prescaler
//   clk   - rising-edge clock
//   clear - synchronous active-high clear of count and prescaler
//   z     - registered count, advances every DIV enabled edges, wraps modulo 2^WIDTH
module counter #(
  parameter int WIDTH = 2,
  parameter int DIV   = 1
) (
  input  logic             clk,
  input  logic             clear,
  output logic [WIDTH-1:0] z
);
  if (DIV == 1) begin : g_nodiv
    always_ff @(posedge clk)
      z <= clear ? '0 : z + WIDTH'(1);
  end else begin : g_div
    localparam int PW = $clog2(DIV);
    logic [PW-1:0] pre;
    logic          roll;
    always_comb roll = pre == PW'(DIV - 1);
    always_ff @(posedge clk)
      if (clear) begin
        z   <= '0;
        pre <= '0;
      end else begin
        pre <= roll ? '0 : pre + PW'(1);
        z   <= roll ? z + WIDTH'(1) : z;
      end
  end
endmodule

// File: tb/tb_counter.sv
// tb_counter: directed vector checks of counter at default, DIV=3 and WIDTH=3 settings
module tb_counter;
  logic clk = 0;
  logic clr2 = 1, clr3 = 1, clrw = 1;
  logic [1:0] z2, z3;
  logic [2:0] zw;
  int passed = 0, total = 0;

  typedef struct { logic c; int z; } vec_t;
  vec_t v[$];

  counter dut2 (.clk(clk), .clear(clr2), .z(z2));
  counter #(.WIDTH(2), .DIV(3)) dut3 (.clk(clk), .clear(clr3), .z(z3));
  counter #(.WIDTH(3), .DIV(1)) dutw (.clk(clk), .clear(clrw), .z(zw));

  always #10 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic add(input logic c, input int z, input int n = 1);
    for (int i = 0; i < n; i++) v.push_back('{c, z});
  endtask

  initial begin
    int e3[$];
    int ew[$];
    add(1, 0); add(0, 1); add(0, 2); add(0, 3); add(0, 0); add(0, 1);
    add(0, 2); add(0, 3); add(1, 0); add(0, 1); add(0, 2); add(1, 0); add(0, 1);
    add(1, 0, 10); add(0, 1); add(0, 2);
    for (int p = 0; p < 3; p++) begin
      add(1, 0, 3); add(0, 1); add(0, 2); add(0, 3);
    end
    @(negedge clk);
    foreach (v[i]) begin
      clr2 = v[i].c;
      @(posedge clk); #1;
      chk($sformatf("def_vec%0d", i), int'(z2), v[i].z);
      @(negedge clk);
    end
    // clear pulse that does not span a rising edge must be ignored
    #2 clr2 = 1; #3 clr2 = 0;
    @(posedge clk); #1;
    chk("glitch", int'(z2), 0);

    e3 = '{0, 0, 0, 1, 1, 1, 2, 2, 2, 3, 3, 3, 0, 0, 0, 1, 1};
    @(negedge clk);
    foreach (e3[i]) begin
      clr3 = (i == 0);
      @(posedge clk); #1;
      chk($sformatf("div3_seq%0d", i), int'(z3), e3[i]);
      @(negedge clk);
    end
    e3 = '{0, 0, 0, 1, 1};
    foreach (e3[i]) begin
      clr3 = (i == 0);
      @(posedge clk); #1;
      chk($sformatf("div3_midclr%0d", i), int'(z3), e3[i]);
      @(negedge clk);
    end

    ew = '{0, 1, 2, 3, 4, 5, 6, 7, 0, 1};
    foreach (ew[i]) begin
      clrw = (i == 0);
      @(posedge clk); #1;
      chk($sformatf("w3_seq%0d", i), int'(zw), ew[i]);
      @(negedge clk);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
